// File: rtl/line_pkg.sv
// line_pkg: shared state and pixel types for the line rasteriser, triangle walker and pixel writer
package line_pkg;
   localparam int CW_DEF = 16;
   typedef enum logic [1:0] {IDLE, SETUP, DRAW, DONE} state_t;
   typedef struct packed {
      logic signed [CW_DEF-1:0] x;
      logic signed [CW_DEF-1:0] y;
      logic                     last;
   } pixel_t;
endpackage

// File: rtl/bresenham_step.sv
// bresenham_step: one combinational Bresenham step; x and/or y advance by their sign, err is rebalanced
module bresenham_step #(
   parameter int CW   = 16,
   parameter int ERRW = CW + 2
) (
   input  logic signed [ERRW-1:0] err,
   input  logic signed [ERRW-1:0] dx,
   input  logic signed [ERRW-1:0] dy,
   input  logic                   sx,
   input  logic                   sy,
   input  logic signed [CW-1:0]   x,
   input  logic signed [CW-1:0]   y,
   output logic signed [ERRW-1:0] err_nxt,
   output logic signed [CW-1:0]   x_nxt,
   output logic signed [CW-1:0]   y_nxt
);
   logic signed [ERRW-1:0] e2;
   logic                   step_x, step_y;
   // |err| never exceeds max(dx,dy), so doubling it still fits in ERRW bits
   assign e2      = err <<< 1;
   assign step_x  = e2 >= -dy;
   assign step_y  = e2 <= dx;
   assign err_nxt = err - (step_x ? dy : '0) + (step_y ? dx : '0);
   assign x_nxt   = step_x ? (sx ? x - CW'(1) : x + CW'(1)) : x;
   assign y_nxt   = step_y ? (sy ? y - CW'(1) : y + CW'(1)) : y;
endmodule

// File: rtl/bresenham_line_gen.sv
// bresenham_line_gen: all-octant Bresenham rasteriser streaming one pixel per cycle on valid/ready
module bresenham_line_gen
   import line_pkg::*;
#(
   parameter int CW   = CW_DEF,
   parameter int ERRW = CW + 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic signed [CW-1:0] x0,
   input  logic signed [CW-1:0] y0,
   input  logic signed [CW-1:0] x1,
   input  logic signed [CW-1:0] y1,
   output logic                 busy,
   output logic                 pix_valid,
   input  logic                 pix_ready,
   output logic signed [CW-1:0] pix_x,
   output logic signed [CW-1:0] pix_y,
   output logic                 pix_last,
   output logic                 done
);
   state_t                 state_q, state_d;
   logic signed [CW-1:0]   x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
   logic signed [CW-1:0]   pix_x_q, pix_x_d, pix_y_q, pix_y_d, x_step, y_step;
   logic signed [ERRW-1:0] dx_q, dx_d, dy_q, dy_d, err_q, err_d, ddx, ddy, err_step;
   logic                   sx_q, sx_d, sy_q, sy_d;
   logic                   valid_q, valid_d, last_q, last_d, busy_q, busy_d, done_q, done_d;

   assign ddx = ERRW'(x1_q) - ERRW'(x0_q);
   assign ddy = ERRW'(y1_q) - ERRW'(y0_q);

   bresenham_step #(.CW(CW), .ERRW(ERRW)) u_step (
      .err(err_q), .dx(dx_q), .dy(dy_q), .sx(sx_q), .sy(sy_q), .x(pix_x_q), .y(pix_y_q),
      .err_nxt(err_step), .x_nxt(x_step), .y_nxt(y_step)
   );

   always_comb begin
      state_d = state_q;
      x0_d    = x0_q;
      y0_d    = y0_q;
      x1_d    = x1_q;
      y1_d    = y1_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      sx_d    = sx_q;
      sy_d    = sy_q;
      err_d   = err_q;
      pix_x_d = pix_x_q;
      pix_y_d = pix_y_q;
      case (state_q)
         IDLE: if (start) begin
            x0_d    = x0;
            y0_d    = y0;
            x1_d    = x1;
            y1_d    = y1;
            state_d = SETUP;
         end
         SETUP: begin
            dx_d    = ddx[ERRW-1] ? -ddx : ddx;
            dy_d    = ddy[ERRW-1] ? -ddy : ddy;
            sx_d    = ddx[ERRW-1];
            sy_d    = ddy[ERRW-1];
            err_d   = dx_d - dy_d;
            pix_x_d = x0_q;
            pix_y_d = y0_q;
            state_d = DRAW;
         end
         DRAW: if (pix_ready) begin
            if (last_q) state_d = DONE;
            else begin
               err_d   = err_step;
               pix_x_d = x_step;
               pix_y_d = y_step;
            end
         end
         default: state_d = IDLE;
      endcase
      // outputs are registered off the next state so they line up with it
      valid_d = state_d == DRAW;
      busy_d  = state_d != IDLE;
      done_d  = state_d == DONE;
      last_d  = valid_d && pix_x_d == x1_d && pix_y_d == y1_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x0_q    <= '0;
         y0_q    <= '0;
         x1_q    <= '0;
         y1_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         sx_q    <= 1'b0;
         sy_q    <= 1'b0;
         err_q   <= '0;
         pix_x_q <= '0;
         pix_y_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x0_q    <= x0_d;
         y0_q    <= y0_d;
         x1_q    <= x1_d;
         y1_q    <= y1_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         sx_q    <= sx_d;
         sy_q    <= sy_d;
         err_q   <= err_d;
         pix_x_q <= pix_x_d;
         pix_y_q <= pix_y_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign busy      = busy_q;
   assign pix_valid = valid_q;
   assign pix_x     = pix_x_q;
   assign pix_y     = pix_y_q;
   assign pix_last  = last_q;
   assign done      = done_q;
endmodule

// File: tb/tb_bresenham_line_gen.sv
// tb_bresenham_line_gen: random-backpressure line streams checked against a software Bresenham model
module tb_bresenham_line_gen;
   localparam int CW = 16;
   logic                 clk = 1'b0, rst_n = 1'b0, start = 1'b0, pix_ready = 1'b0;
   logic signed [CW-1:0] x0 = '0, y0 = '0, x1 = '0, y1 = '0, pix_x, pix_y;
   logic                 busy, pix_valid, pix_last, done;
   int                   checks = 0, errors = 0;
   int                   exp_x[$], exp_y[$];

   always #5 clk = ~clk;

   bresenham_line_gen #(.CW(CW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .x0(x0), .y0(y0), .x1(x1), .y1(y1),
      .busy(busy), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
      .pix_last(pix_last), .done(done)
   );

   task automatic chk(input string tag, input logic signed [31:0] got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic void model(input int ax0, ay0, ax1, ay1);
      int dx = ax1 >= ax0 ? ax1 - ax0 : ax0 - ax1;
      int dy = ay1 >= ay0 ? ay1 - ay0 : ay0 - ay1;
      int sx = ax1 >= ax0 ? 1 : -1;
      int sy = ay1 >= ay0 ? 1 : -1;
      int err = dx - dy, x = ax0, y = ay0, e2;
      exp_x.delete();
      exp_y.delete();
      for (int i = 0; i < 70000; i++) begin
         exp_x.push_back(x);
         exp_y.push_back(y);
         if (x == ax1 && y == ay1) break;
         e2 = 2 * err;
         if (e2 >= -dy) begin err -= dy; x += sx; end
         if (e2 <= dx) begin err += dx; y += sy; end
      end
   endfunction

   task automatic run_line(input int ax0, ay0, ax1, ay1, input int pct, input int mid_idx,
                           input bit hold, input int nx0, ny0, nx1, ny1, output int cycles);
      int idx = 0, n, sx_s = 0, sy_s = 0, adx, ady;
      bit got_last = 0, stalled = 0;
      logic l_s = 1'b0;
      model(ax0, ay0, ax1, ay1);
      n = exp_x.size();
      adx = ax1 >= ax0 ? ax1 - ax0 : ax0 - ax1;
      ady = ay1 >= ay0 ? ay1 - ay0 : ay0 - ay1;
      cycles = 0;
      start = 1'b1;
      x0 = CW'(ax0); y0 = CW'(ay0); x1 = CW'(ax1); y1 = CW'(ay1);
      @(negedge clk);
      if (hold) begin
         x0 = CW'(nx0); y0 = CW'(ny0); x1 = CW'(nx1); y1 = CW'(ny1);
      end else begin
         start = 1'b0;
         x0 = CW'($urandom); y0 = CW'($urandom); x1 = CW'($urandom); y1 = CW'($urandom);
      end
      chk("setup_busy", busy, 1);
      chk("setup_valid", pix_valid, 0);
      @(negedge clk);
      chk("first_valid", pix_valid, 1);
      while (!got_last && cycles < 1000) begin
         if (stalled) begin
            chk("stall_x", pix_x, sx_s);
            chk("stall_y", pix_y, sy_s);
            chk("stall_last", pix_last, int'(l_s));
         end
         chk("valid", pix_valid, 1);
         pix_ready = $urandom_range(99) < pct;
         if (!hold) begin
            start = idx == mid_idx;
            if (start) begin x0 = -9; y0 = 9; x1 = 9; y1 = -9; end
         end
         if (pix_ready && pix_valid) begin
            if (idx < n) begin
               chk("pix_x", pix_x, exp_x[idx]);
               chk("pix_y", pix_y, exp_y[idx]);
               chk("pix_last", pix_last, idx == n - 1 ? 1 : 0);
            end
            got_last = pix_last;
            idx++;
            stalled = 0;
         end else begin
            sx_s = pix_x; sy_s = pix_y; l_s = pix_last;
            stalled = 1;
         end
         @(negedge clk);
         cycles++;
      end
      if (!hold) start = 1'b0;
      chk("pix_count", idx, (adx > ady ? adx : ady) + 1);
      chk("done_pulse", done, 1);
      chk("done_busy", busy, 1);
      chk("done_valid", pix_valid, 0);
      pix_ready = 1'($urandom_range(1));
      @(negedge clk);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      int cyc;
      #3;
      chk("rst_valid", pix_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_last", pix_last, 0);
      chk("rst_x", pix_x, 0);
      chk("rst_y", pix_y, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_line(1, 2, 20, 10, 100, -1, 0, 0, 0, 0, 0, cyc);
      chk("consecutive", cyc, 20);
      run_line(5, 5, 2, -3, 100, -1, 0, 0, 0, 0, 0, cyc);
      run_line(7, 7, 7, 7, 100, -1, 0, 0, 0, 0, 0, cyc);
      chk("degenerate_cycles", cyc, 1);
      run_line(0, 0, 10, 0, 50, -1, 0, 0, 0, 0, 0, cyc);
      run_line(0, 0, 6, -3, 70, 3, 0, 0, 0, 0, 0, cyc);
      run_line(2, 1, 5, 3, 100, -1, 1, 0, 0, -4, 4, cyc);
      run_line(0, 0, -4, 4, 100, -1, 0, 0, 0, 0, 0, cyc);
      chk("diag_cycles", cyc, 5);
      start = 1'b1;
      x0 = 0; y0 = 0; x1 = 100; y1 = 50;
      @(negedge clk);
      start = 1'b0;
      pix_ready = 1'b1;
      repeat (10) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_valid", pix_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_x", pix_x, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_done", done, 0);
         chk("post_rst_busy", busy, 0);
      end
      run_line(3, -2, -5, 4, 80, -1, 0, 0, 0, 0, 0, cyc);
      run_line(32760, -32768, 32767, -32750, 60, -1, 0, 0, 0, 0, 0, cyc);
      run_line(-32768, 32767, -32760, 32760, 60, -1, 0, 0, 0, 0, 0, cyc);
      for (int i = 0; i < 16; i++)
         run_line(int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                  int'($urandom_range(80)) - 40, int'($urandom_range(80)) - 40,
                  int'($urandom_range(100, 30)), -1, 0, 0, 0, 0, 0, cyc);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bresenham_line_gen.md
Name: bresenham_line_gen

Overview:
Parametrised, all-octant Bresenham line rasteriser with runtime endpoints. Emits one pixel coordinate per cycle on a valid/ready stream. It replaces the fixed-endpoint, first-octant-only line drawer. It feeds the pixel writer / framebuffer arbiter and is reused by the triangle edge walker.

Parameters:
CW, 16, coordinate width in bits; coordinates are two's-complement signed.
ERRW, CW+2, internal error-term width in bits; must not be set below CW+2.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request a new line; sampled only in IDLE
x0  in  CW  start x, signed; latched on an accepted start
y0  in  CW  start y, signed; latched on an accepted start
x1  in  CW  end x, signed; latched on an accepted start
y1  in  CW  end y, signed; latched on an accepted start
busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive
pix_valid  out  1  pix_x/pix_y hold a valid pixel
pix_ready  in  1  consumer accepts the pixel when pix_valid && pix_ready
pix_x  out  CW  current pixel x, signed
pix_y  out  CW  current pixel y, signed
pix_last  out  1  qualifies the endpoint pixel; valid only with pix_valid
done  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=IDLE.
  - busy, pix_valid, pix_last and done are 0.
  - pix_x, pix_y and all internal registers are 0.
  - Reset mid-line abandons the line; no done pulse is produced.
- States: IDLE, SETUP, DRAW, DONE.
- IDLE: when start=1, latch x0/y0/x1/y1 and go to SETUP. Otherwise stay in IDLE.
- SETUP (1 cycle):
  - dx=|x1-x0|, dy=|y1-y0|, computed in ERRW bits with no overflow for any CW inputs.
  - sx=+1 if x1>=x0, else -1; sy=+1 if y1>=y0, else -1.
  - err=dx-dy; pix_x=x0, pix_y=y0.
  - Next state DRAW.
- DRAW:
  - pix_valid=1.
  - pix_last=1 when (pix_x==x1 && pix_y==y1).
  - On handshake with pix_last=0, compute e2=2*err (ERRW bits):
    - if e2 >= -dy: err -= dy and pix_x += sx;
    - if e2 <= dx: err += dx and pix_y += sy;
    - both updates may apply in the same cycle (diagonal step).
  - On handshake with pix_last=1: go to DONE.
- DONE: done=1 and busy=1 for exactly one cycle, then IDLE.
- Latency: an accepted start at cycle N gives the first pix_valid at cycle N+2.
- Throughput: 1 pixel per cycle while pix_ready=1.
- Pixel count: exactly max(dx,dy)+1. Both endpoints are included; no duplicate pixels.
- Backpressure: while pix_valid && !pix_ready, pix_x, pix_y and pix_last hold stable and err does not change. pix_valid never drops without a handshake.
- start asserted outside IDLE is ignored; changes to x0..y1 after latching are ignored.
- start held high continuously: a new line is accepted in the IDLE cycle after DONE.
- Degenerate line (x0==x1, y0==y1): exactly one pixel with pix_last=1, then DONE.
- Horizontal, vertical, 45-degree lines and all 8 octants use the same datapath.
- The endpoint-compare termination is safe because coordinates are never extended or truncated internally.

Decomposition:
- Shared package line_pkg holds:
  - the state enum (IDLE/SETUP/DRAW/DONE);
  - the default CW;
  - a pixel struct {x, y, last} reused by the triangle walker and the pixel writer.
- Optional sub-module bresenham_step: combinational; inputs err, dx, dy, sx, sy, x, y; outputs next err/x/y.
  - Keeps the stepping rule in one place for reuse by the triangle edge walker.
  - The FSM and handshake stay in bresenham_line_gen.

Test Plan:
1. (1,2)->(20,10), pix_ready=1 -> 20 pixels on consecutive cycles; first (1,2), second (2,2), last (20,10) with pix_last=1; done one cycle after the last handshake; first pixel at start+2.
2. (5,5)->(2,-3), steep negative octant -> 9 pixels; y strictly decreasing 5..-3; x non-increasing 5..2; final pixel (2,-3) flagged last.
3. (7,7)->(7,7) -> exactly one pixel (7,7) with pix_last=1, then a done pulse, then IDLE with busy=0.
4. (0,0)->(10,0) with pix_ready toggling in a random pattern -> 11 pixels x=0..10, y=0; the outputs stay stable during every stall; no pixel is lost or duplicated; result matches a software Bresenham model.
5. start re-asserted with new coordinates mid-line -> ignored; the current line completes unchanged. Then, with start held high: line (0,0)->(-4,4) begins in the IDLE cycle after DONE and gives 5 diagonal pixels.
6. rst_n pulsed low during DRAW of (0,0)->(100,50) -> pix_valid, busy and done go to 0 immediately (asynchronously); no done pulse; the next start runs a fresh line correctly.
